bin_to_bcd_seq: RTL and testbench

- Iterative double-dabble (shift-and-add-3) converter from BIN_W-bit binary to DIGITS packed BCD digits, with a start/valid handshake.
- Parametrised successor to the team's fixed 8-bit combinational hundreds/tens/ones converter.
- Trades one cycle per input bit for a small, width-independent datapath.
- Sits between arithmetic blocks (e.g. multiplier results) and display/readout logic.

---
 rtl/bin_to_bcd_pkg.sv | 27 ++
 rtl/bcd_add3.sv | 16 +
 rtl/bin_to_bcd_seq.sv | 140 ++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package bin_to_bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Decimal digits needed to represent 2**bin_w - 1.
    function automatic int unsigned min_bcd_digits(input int unsigned bin_w);
        longint unsigned max_val;
        int unsigned     digits;
        max_val = (64'd1 << bin_w) - 64'd1;
        digits  = 1;
        for (int i = 0; i < 20; i++) begin
            max_val = max_val / 64'd10;
            if (max_val != 64'd0) begin
                digits++;
            end
        end
        return digits;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
module bcd_add3
    import bin_to_bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] dig,
    output logic [BCD_DIGIT_W-1:0] adj_c
);

    always_comb begin
        adj_c = dig;
        if (dig >= BCD_DIGIT_W'(5)) begin
            adj_c = dig + BCD_DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble converter, one input bit per cycle, start/valid handshake.
// Optional two's-complement input with a neg output when BIN_TO_BCD_SIGNED_EN is defined.
module bin_to_bcd_seq
    import bin_to_bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin,
    output logic                          ready,
    output logic                          busy,
    output logic                          valid,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
`ifdef BIN_TO_BCD_SIGNED_EN
    ,
    output logic                          neg
`endif
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned SR_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
`ifdef BIN_TO_BCD_SIGNED_EN
    localparam int unsigned MAG_W = BIN_W - 1;
`else
    localparam int unsigned MAG_W = BIN_W;
`endif

    if (BIN_W < 2) begin : g_bin_w_check
        $error("bin_to_bcd_seq: BIN_W must be at least 2");
    end
    if (DIGITS < min_bcd_digits(MAG_W)) begin : g_digits_check
        $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
    end

    state_t             state, state_next;
    logic [SR_W-1:0]    sr, sr_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [BCD_W-1:0]   bcd_next;
    logic [BCD_W-1:0]   corr;
    logic [BIN_W-1:0]   load_val;
    logic               valid_next;
    logic               ready_next;
    logic               busy_next;
`ifdef BIN_TO_BCD_SIGNED_EN
    logic               neg_sr, neg_sr_next;
    logic               neg_next;
`endif

    // All digits are corrected from the uncorrected register, never from each other.
    for (genvar k = 0; k < DIGITS; k++) begin : g_add3
        bcd_add3 u_add3 (
            .dig   (sr[BIN_W + BCD_DIGIT_W*k +: BCD_DIGIT_W]),
            .adj_c (corr[BCD_DIGIT_W*k +: BCD_DIGIT_W])
        );
    end

    // Operand as loaded into the shift register (magnitude in signed builds).
`ifdef BIN_TO_BCD_SIGNED_EN
    assign load_val = bin[BIN_W-1] ? ((~bin) + BIN_W'(1)) : bin;
`else
    assign load_val = bin;
`endif

    always_comb begin
        state_next = state;
        sr_next    = sr;
        cnt_next   = cnt;
        bcd_next   = bcd;
        valid_next = 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
        neg_sr_next = neg_sr;
        neg_next    = neg;
`endif
        unique case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (start) begin
                    sr_next    = {BCD_W'(0), load_val};
                    cnt_next   = CNT_W'(BIN_W);
                    state_next = SHIFT;
`ifdef BIN_TO_BCD_SIGNED_EN
                    neg_sr_next = bin[BIN_W-1];
`endif
                end
            end
            SHIFT: begin
                sr_next  = SR_W'({corr, sr[BIN_W-1:0], 1'b0});
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    bcd_next   = sr_next[SR_W-1 -: BCD_W];
                    valid_next = 1'b1;
                    state_next = DONE;
`ifdef BIN_TO_BCD_SIGNED_EN
                    neg_next = neg_sr;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
        ready_next = (state_next != SHIFT);
        busy_next  = (state_next == SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            bcd   <= '0;
            valid <= 1'b0;
            ready <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            sr    <= sr_next;
            cnt   <= cnt_next;
            bcd   <= bcd_next;
            valid <= valid_next;
            ready <= ready_next;
            busy  <= busy_next;
        end
    end

`ifdef BIN_TO_BCD_SIGNED_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_sr <= 1'b0;
            neg    <= 1'b0;
        end else begin
            neg_sr <= neg_sr_next;
            neg    <= neg_next;
        end
    end
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: an 8-bit/3-digit and a 10-bit/4-digit instance.
module tb_bin_to_bcd_seq;

    typedef struct packed {
        logic        n;
        logic [15:0] b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0;
    logic [7:0]  bin8 = '0;
    logic        ready8, busy8, valid8;
    logic [11:0] bcd8;
    logic        start10 = 1'b0;
    logic [9:0]  bin10 = '0;
    logic        ready10, busy10, valid10;
    logic [15:0] bcd10;
`ifdef BIN_TO_BCD_SIGNED_EN
    logic        neg8, neg10;
`endif

    int   checks = 0;
    int   errors = 0;
    int   vcnt8  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (valid8) vcnt8 <= vcnt8 + 1;
    end

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .bin   (bin8),
        .ready (ready8),
        .busy  (busy8),
        .valid (valid8),
        .bcd   (bcd8)
`ifdef BIN_TO_BCD_SIGNED_EN
        ,
        .neg   (neg8)
`endif
    );

    bin_to_bcd_seq #(.BIN_W(10), .DIGITS(4)) dut10 (
        .clk   (clk),
        .rst   (rst),
        .start (start10),
        .bin   (bin10),
        .ready (ready10),
        .busy  (busy10),
        .valid (valid10),
        .bcd   (bcd10)
`ifdef BIN_TO_BCD_SIGNED_EN
        ,
        .neg   (neg10)
`endif
    );

    // Reference: decimal digits by division, sign handled on the raw operand.
    function automatic exp_t model(input int w, input int v);
        exp_t r;
        int   m;
        m   = v;
        r.n = 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
        if (v >= (1 << (w - 1))) begin
            m   = (1 << w) - v;
            r.n = 1'b1;
        end
`endif
        r.b = '0;
        for (int d = 0; d < 4; d++) begin
            r.b[4*d +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    // Drives start for one cycle from the current negedge and records the expectation.
    task automatic accept(input int which, input int val, input exp_t e);
        if (which != 0) begin
            start10 = 1'b1;
            bin10   = 10'(val);
        end else begin
            start8 = 1'b1;
            bin8   = 8'(val);
        end
        sb.push_back(e);
        @(negedge clk);
        start8  = 1'b0;
        start10 = 1'b0;
        bin8    = 8'($urandom);
        bin10   = 10'($urandom);
    endtask

    task automatic wait_valid(input int which, input int limit, output int lat);
        lat = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if ((which != 0) ? valid10 : valid8) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic pop(output exp_t e);
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (bcd8 !== 12'h000) begin errors++; $display("FAIL reset_bcd got %h want 000", bcd8); end
        checks++; if (valid8 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy8); end
        checks++; if (ready8 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready8); end
        repeat (5) @(negedge clk);
        checks++; if (bcd8 !== 12'h000 || vcnt8 != 0) begin
            errors++; $display("FAIL idle_hold got bcd %h valids %0d want 000 and 0", bcd8, vcnt8);
        end
    endtask

    task automatic test_basic();
        int          vals[3];
        logic [11:0] exps[3];
        logic        negs[3];
        exp_t        e;
        int          lat;
`ifdef BIN_TO_BCD_SIGNED_EN
        vals = '{128, 255, 127};
        exps = '{12'h128, 12'h001, 12'h127};
        negs = '{1'b1, 1'b1, 1'b0};
`else
        vals = '{255, 0, 170};
        exps = '{12'h255, 12'h000, 12'h170};
        negs = '{1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 3; i++) begin
            accept(0, vals[i], {negs[i], 4'h0, exps[i]});
            checks++; if (busy8 !== 1'b1 || ready8 !== 1'b0) begin
                errors++; $display("FAIL basic_busy[%0d] got busy %b ready %b want 1 0", i, busy8, ready8);
            end
            wait_valid(0, 20, lat);
            pop(e);
            checks++; if (lat != 8) begin errors++; $display("FAIL basic_latency[%0d] got %0d want 8", i, lat); end
            checks++; if (bcd8 !== e.b[11:0]) begin errors++; $display("FAIL basic_bcd[%0d] got %h want %h", i, bcd8, e.b[11:0]); end
`ifdef BIN_TO_BCD_SIGNED_EN
            checks++; if (neg8 !== e.n) begin errors++; $display("FAIL basic_neg[%0d] got %b want %b", i, neg8, e.n); end
`endif
            @(negedge clk);
            checks++; if (valid8 !== 1'b0 || bcd8 !== e.b[11:0] || ready8 !== 1'b1) begin
                errors++; $display("FAIL basic_pulse[%0d] got valid %b bcd %h ready %b want 0 %h 1", i, valid8, bcd8, ready8, e.b[11:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        int   c;
        c = vcnt8;
        accept(0, 123, model(8, 123));
        wait_valid(0, 20, lat);
        pop(e);
        checks++; if (lat != 8 || bcd8 !== e.b[11:0]) begin
            errors++; $display("FAIL b2b_first got lat %0d bcd %h want 8 %h", lat, bcd8, e.b[11:0]);
        end
        checks++; if (ready8 !== 1'b1) begin errors++; $display("FAIL b2b_done_ready got %b want 1", ready8); end
        accept(0, 99, model(8, 99));
        start8 = 1'b1;
        bin8   = 8'd7;
        @(negedge clk);
        start8 = 1'b0;
        wait_valid(0, 20, lat);
        pop(e);
        checks++; if (lat != 7) begin errors++; $display("FAIL b2b_latency got %0d want 7", lat); end
        checks++; if (bcd8 !== e.b[11:0]) begin errors++; $display("FAIL b2b_bcd got %h want %h", bcd8, e.b[11:0]); end
        repeat (15) @(negedge clk);
        checks++; if (vcnt8 != c + 2) begin errors++; $display("FAIL b2b_pulses got %0d want %0d", vcnt8 - c, 2); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   lat;
        int   c;
        accept(0, 200, model(8, 200));
        repeat (4) @(negedge clk);
        c   = vcnt8;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        checks++; if (valid8 !== 1'b0 || bcd8 !== 12'h000 || ready8 !== 1'b1 || busy8 !== 1'b0) begin
            errors++; $display("FAIL abort_state got valid %b bcd %h ready %b busy %b want 0 000 1 0", valid8, bcd8, ready8, busy8);
        end
        repeat (12) @(negedge clk);
        checks++; if (vcnt8 != c || bcd8 !== 12'h000) begin
            errors++; $display("FAIL abort_quiet got valids %0d bcd %h want 0 000", vcnt8 - c, bcd8);
        end
        accept(0, 200, model(8, 200));
        wait_valid(0, 20, lat);
        pop(e);
        checks++; if (lat != 8 || bcd8 !== e.b[11:0]) begin
            errors++; $display("FAIL abort_retry got lat %0d bcd %h want 8 %h", lat, bcd8, e.b[11:0]);
        end
    endtask

    task automatic test_wide();
        exp_t e;
        int   lat;
`ifdef BIN_TO_BCD_SIGNED_EN
        accept(1, 1023, {1'b1, 16'h0001});
`else
        accept(1, 1023, {1'b0, 16'h1023});
`endif
        wait_valid(1, 20, lat);
        pop(e);
        checks++; if (lat != 10) begin errors++; $display("FAIL wide_latency got %0d want 10", lat); end
        checks++; if (bcd10 !== e.b) begin errors++; $display("FAIL wide_max got %h want %h", bcd10, e.b); end
        @(negedge clk);
        for (int v = 0; v < 1024; v++) begin
            accept(1, v, model(10, v));
            wait_valid(1, 15, lat);
            pop(e);
            checks++;
`ifdef BIN_TO_BCD_SIGNED_EN
            if (lat < 0 || bcd10 !== e.b || neg10 !== e.n) begin
                errors++; $display("FAIL sweep[%0d] got lat %0d bcd %h neg %b want %h %b", v, lat, bcd10, neg10, e.b, e.n);
            end
`else
            if (lat < 0 || bcd10 !== e.b) begin
                errors++; $display("FAIL sweep[%0d] got lat %0d bcd %h want %h", v, lat, bcd10, e.b);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_mid();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
